// File: rtl/decode_stage_ctrl_pkg.sv
// Shared decode defines, states and entry bundle for decode_stage_ctrl.
// DECODE_ILLEGAL_TRAP_EN enables the illegal-opcode output in the top.
`ifndef DECODE_DEFINES_V
`define DECODE_DEFINES_V
`define INST_WIDTH 32
`define IMM_ID     32
`define OP_IMM    7'b0010011
`define OP_LOAD   7'b0000011
`define OP_JALR   7'b1100111
`define OP_STORE  7'b0100011
`define OP_BRANCH 7'b1100011
`define OP_JAL    7'b1101111
`define OP_LUI    7'b0110111
`define OP_AUIPC  7'b0010111
`define OP_REG    7'b0110011
`define OP_SYSTEM 7'b1110011
`endif

package decode_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [`INST_WIDTH-1:0] inst;
    logic [31:0]            pc;
    logic [`IMM_ID-1:0]     imm;
  } if_id_t;

  function automatic logic op_legal(input logic [6:0] op);
    return (op == `OP_IMM)    || (op == `OP_LOAD)  ||
           (op == `OP_JALR)   || (op == `OP_STORE) ||
           (op == `OP_BRANCH) || (op == `OP_JAL)   ||
           (op == `OP_LUI)    || (op == `OP_AUIPC) ||
           (op == `OP_REG)    || (op == `OP_SYSTEM);
  endfunction

endpackage

// File: rtl/decode_stage_ctrl_imm_ext.sv
// RV32I immediate extraction on the enqueue path (combinational).
// Unknown opcodes yield a zero immediate.
module decode_imm_ext
  import decode_stage_ctrl_pkg::*;
(
  input  logic [`INST_WIDTH-1:0] inst,
  output logic [`IMM_ID-1:0]     imm
);

  logic [6:0] op;
  assign op = inst[6:0];

  always_comb begin
    imm = '0;
    unique case (1'b1)
      (op == `OP_IMM),
      (op == `OP_LOAD),
      (op == `OP_JALR):
        imm = {{20{inst[31]}}, inst[31:20]};
      (op == `OP_STORE):
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      (op == `OP_BRANCH):
        imm = {{19{inst[31]}}, inst[31], inst[7],
               inst[30:25], inst[11:8], 1'b0};
      (op == `OP_JAL):
        imm = {{11{inst[31]}}, inst[31], inst[19:12],
               inst[20], inst[30:21], 1'b0};
      (op == `OP_LUI),
      (op == `OP_AUIPC):
        imm = {inst[31:12], 12'h000};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage_ctrl.sv
// Two-entry decode buffer with EMPTY/HALF/FULL FSM and registered immediates.
// Define DECODE_ILLEGAL_TRAP_EN to add the illegal-opcode output.
module decode_stage_ctrl
  import decode_stage_ctrl_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   f_valid,
  output logic                   f_ready,
  input  logic [`INST_WIDTH-1:0] f_inst,
  input  logic [31:0]            f_pc,
  output logic                   d_valid,
  input  logic                   d_ready,
  output logic [`INST_WIDTH-1:0] d_inst,
  output logic [31:0]            d_pc,
  output logic [`IMM_ID-1:0]     d_imm,
  input  logic                   flush,
  input  logic                   hold
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic                   illegal
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);

  buf_state_e state_q, state_d;
  logic [PW-1:0] wptr, rptr;
  if_id_t buf_q [BUF_DEPTH];
  if_id_t ent, head;
  logic enq, deq;

  decode_imm_ext u_imm (
    .inst (f_inst),
    .imm  (ent.imm)
  );

  assign ent.inst = f_inst;
  assign ent.pc   = f_pc;
  assign head     = buf_q[rptr];

  assign f_ready = (state_q != FULL) && !flush;
  assign d_valid = (state_q != EMPTY) && !hold && !flush;
  assign enq     = f_valid && f_ready;
  assign deq     = d_valid && d_ready;

  assign d_inst = head.inst;
  assign d_pc   = head.pc;
  assign d_imm  = head.imm;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal = d_valid && !op_legal(head.inst[6:0]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (enq && !deq) begin
      state_d = (state_q == EMPTY) ? HALF : FULL;
    end else if (deq && !enq) begin
      state_d = (state_q == FULL) ? HALF : EMPTY;
    end
  end

  // flush drops any enqueue/dequeue in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (enq) begin
        buf_q[wptr] <= ent;
        wptr        <= wptr + PW'(1);
      end
      if (deq) rptr <= rptr + PW'(1);
    end
  end

endmodule
